// File: rtl/noc_flit_pkg.sv
// Shared flit geometry, node-id type and TX state encoding for the PE traffic interface.
// Flit layout is {dest[3:0], payload[15:0]}, where payload is {src_id[3:0], seq[11:0]}.
package noc_flit_pkg;

  localparam int FLIT_W    = 20;
  localparam int PAYLOAD_W = 16;
  localparam int DEST_HI   = 19;
  localparam int DEST_LO   = 16;
  localparam int SEQ_W     = 12;

  typedef logic [3:0] node_id_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_t;

  function automatic logic [FLIT_W-1:0] make_flit(
    input node_id_t         dest,
    input node_id_t         src,
    input logic [SEQ_W-1:0] seq
  );
    return {dest, src, seq};
  endfunction

endpackage

// File: rtl/pe_traffic_interface_if.sv
// Local-port link between a processing element and its router.
// The master modport is the PE side: it sees the eject stream and returned credits, and drives the inject stream.
interface pe_traffic_interface_if;
  import noc_flit_pkg::*;

  logic [FLIT_W-1:0] datain;
  logic              in_valid;
  logic              ci;
  logic [FLIT_W-1:0] dataout;
  logic              out_valid;

  modport master (
    input  datain,
    input  in_valid,
    input  ci,
    output dataout,
    output out_valid
  );

  modport slave (
    output datain,
    output in_valid,
    output ci,
    input  dataout,
    input  out_valid
  );

endinterface

// File: rtl/noc_credit_counter.sv
// Saturating credit counter. It resets full (MAX) and counts up on inc and down on dec.
// An inc while already full holds the count and raises a sticky overflow error.
module noc_credit_counter #(
  parameter  int MAX   = 4,
  localparam int CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             overflow_err
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

  logic [CNT_W-1:0] count_reg, count_next;
  logic             err_reg, err_next;

  always_comb begin
    count_next = count_reg;
    err_next   = err_reg;
    unique case ({inc, dec})
      2'b10: begin
        if (count_reg == MAX_C) begin
          err_next = 1'b1;
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      2'b01: begin
        if (count_reg != '0) begin
          count_next = count_reg - CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= MAX_C;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  assign count        = count_reg;
  assign nonzero      = (count_reg != '0);
  assign overflow_err = err_reg;

endmodule

// File: rtl/pe_traffic_interface.sv
// PE-side companion of the router's local port. It injects credit-paced bursts of flits
// to one destination, and it captures every ejected flit's payload while counting arrivals.
module pe_traffic_interface
  import noc_flit_pkg::*;
#(
  parameter node_id_t SRC_ID  = 4'd0,
  parameter int       CREDITS = 4,
  parameter int       INJ_GAP = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  pe_traffic_interface_if.master        bus,
  input  logic                          tx_start,
  input  logic [3:0]                    tx_dest,
  input  logic [7:0]                    tx_count,
  output logic                          tx_busy,
  output logic [PAYLOAD_W-1:0]          read,
  output logic [15:0]                   rx_count,
  output logic                          cred_err
);

  localparam int CRED_W = $clog2(CREDITS + 1);
  localparam int GAP_W  = (INJ_GAP > 1) ? $clog2(INJ_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((INJ_GAP > 0) ? INJ_GAP - 1 : 0);

  tx_state_t         state_reg, state_next;
  node_id_t          dest_reg, dest_next;
  logic [7:0]        remaining_reg, remaining_next;
  logic [SEQ_W-1:0]  seq_reg, seq_next;
  logic [GAP_W-1:0]  gap_reg, gap_next;
  logic [FLIT_W-1:0] dataout_reg, dataout_next;
  logic              out_valid_reg, out_valid_next;
  logic              busy_reg, busy_next;
  logic              inject;
  logic              can_send;

  logic [CRED_W-1:0]    cred_count;
  logic                 cred_nonzero;
  logic [PAYLOAD_W-1:0] read_reg;
  logic [15:0]          rx_count_reg;
  logic [CRED_W+3:0]    unused_sigs;

  noc_credit_counter #(
    .MAX (CREDITS)
  ) u_credit (
    .clk          (clk),
    .rst          (rst),
    .inc          (bus.ci),
    .dec          (inject),
    .count        (cred_count),
    .nonzero      (cred_nonzero),
    .overflow_err (cred_err)
  );

  // A credit returned on this edge can pay for this edge's injection.
  assign can_send = cred_nonzero | bus.ci;

  always_comb begin
    state_next     = state_reg;
    dest_next      = dest_reg;
    remaining_next = remaining_reg;
    seq_next       = seq_reg;
    gap_next       = gap_reg;
    dataout_next   = dataout_reg;
    out_valid_next = 1'b0;
    inject         = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (tx_start && (tx_count != 8'd0)) begin
          dest_next      = tx_dest;
          remaining_next = tx_count;
          seq_next       = '0;
          state_next     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (can_send) begin
          inject         = 1'b1;
          out_valid_next = 1'b1;
          dataout_next   = make_flit(dest_reg, SRC_ID, seq_reg);
          remaining_next = remaining_reg - 8'd1;
          seq_next       = seq_reg + SEQ_W'(1);
          if (remaining_reg == 8'd1) begin
            state_next = ST_IDLE;
          end else if (INJ_GAP > 0) begin
            state_next = ST_GAP;
            gap_next   = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_reg == '0) begin
          state_next = ST_SEND;
        end else begin
          gap_next = gap_reg - GAP_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Busy stays high through the cycle that presents the final flit.
    busy_next = (state_next != ST_IDLE) || inject;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      dest_reg      <= '0;
      remaining_reg <= '0;
      seq_reg       <= '0;
      gap_reg       <= '0;
      dataout_reg   <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dest_reg      <= dest_next;
      remaining_reg <= remaining_next;
      seq_reg       <= seq_next;
      gap_reg       <= gap_next;
      dataout_reg   <= dataout_next;
      out_valid_reg <= out_valid_next;
      busy_reg      <= busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_reg     <= '0;
      rx_count_reg <= '0;
    end else if (bus.in_valid) begin
      read_reg     <= bus.datain[PAYLOAD_W-1:0];
      rx_count_reg <= rx_count_reg + 16'd1;
    end
  end

  // The PE consumes only the payload of ejected flits; the credit level itself is not needed here.
  assign unused_sigs = {bus.datain[DEST_HI:DEST_LO], cred_count};

  assign bus.dataout   = dataout_reg;
  assign bus.out_valid = out_valid_reg;
  assign tx_busy       = busy_reg;
  assign read          = read_reg;
  assign rx_count      = rx_count_reg;

endmodule

// File: doc/pe_traffic_interface.md
Name: pe_traffic_interface

Overview:
- Processing-element side of a node: consumes the router's local eject port and drives its local inject port.
- TX: a command-driven traffic generator emits a burst of flits to one destination, paced by credits returned from the router's local input buffer.
- RX: captures every ejected flit's payload into `read` and counts arrivals.
- Drop-in companion of the router's port 5.

Parameters:
- SRC_ID, 4'd0, this node's {cluster,local} id, inserted in every payload
- CREDITS, 4, depth of the router's local input buffer; initial and maximum credit count
- INJ_GAP, 0, idle cycles forced between consecutive injected flits (0 = back-to-back)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- datain  in  20  ejected flit from router
- in_valid  in  1  datain valid this cycle
- ci  in  1  one-cycle credit-return pulse from router (one buffer slot freed)
- tx_start  in  1  start a burst (sampled only in IDLE)
- tx_dest  in  4  burst destination {cluster[1:0],local[1:0]}
- tx_count  in  8  flits in burst; 0 = no-op
- dataout  out  20  flit to router
- out_valid  out  1  dataout valid this cycle
- tx_busy  out  1  burst in progress
- read  out  16  payload of most recent ejected flit
- rx_count  out  16  total flits received
- cred_err  out  1  sticky: credit returned while counter already at CREDITS

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-low.
  - Reset clears everything: dataout=0, out_valid=0, tx_busy=0, read=0, rx_count=0, cred_err=0.
  - Reset loads the credit counter with CREDITS and puts the FSM in IDLE.
  - Reset mid-burst abandons the burst immediately; no partial flit.
- Flit format: [19:18] dest cluster, [17:16] dest local, [15:0] payload.
- Payload format: {SRC_ID[3:0], seq[11:0]}; seq counts 0.. within the burst and wraps mod 4096.
- Credit counter (width clog2(CREDITS+1)):
  - +1 on ci, -1 on inject; both in the same cycle leave it unchanged.
  - ci while at CREDITS: counter holds, cred_err sets (sticky until reset).
  - Never injects at 0; never underflows.
- TX FSM:
  - IDLE: on tx_start with tx_count!=0, latch tx_dest and tx_count, seq=0, tx_busy=1, go to SEND. tx_start with tx_count=0 is ignored.
  - SEND: if credits>0, drive out_valid=1 for exactly one cycle (registered output), decrement remaining, increment seq.
    - remaining reaches 0 -> IDLE, with tx_busy low the cycle after the last flit.
    - else INJ_GAP>0 -> GAP.
    - else stay in SEND.
    - If credits==0, hold in SEND with out_valid=0.
  - GAP: count INJ_GAP cycles with out_valid=0, then SEND.
  - tx_start while busy is ignored.
- Injection timing: a credit seen at the clock edge is usable for that same edge's injection decision (counter value before update plus ci).
- RX: no backpressure toward the router; a valid flit is accepted every cycle in_valid=1.
  - read <= datain[15:0] and rx_count += 1 on each valid flit; wraps 0xFFFF->0.
  - read holds its value when in_valid=0.
- dataout holds the last flit value when out_valid=0.

Decomposition:
- Shared package noc_flit_pkg: FLIT_W=20, PAYLOAD_W=16, DEST_HI=19, DEST_LO=16, SEQ_W=12, node-id typedef (4 bits).
- One sub-module, noc_credit_counter: parameterised max, inc/dec, count, nonzero flag, overflow error.

Test Plan:
- Reset: rst low during activity -> all outputs 0 and credits=CREDITS, both checked while rst is still low.
- Burst within credit: CREDITS=4, INJ_GAP=0, tx_start with dest=4'b1001, count=3, no ci -> 3 consecutive out_valid flits 0x9_0000, 0x9_0001, 0x9_0002 (with SRC_ID=0), then tx_busy=0.
- Credit stall: CREDITS=2, count=5, no ci -> 2 flits then stall. Single ci pulse -> exactly one more flit, next cycle. Total 5 only after 3 ci pulses.
- Simultaneous credit and inject: credits=1, ci asserted on the inject cycle -> counter stays 1 and the next flit goes back-to-back.
- Gap and overflow: INJ_GAP=2, count=3 with ample credits -> flits spaced 3 cycles apart. Then ci pulsed at credits=CREDITS -> cred_err=1 and stays 1.
- RX: in_valid for 3 cycles with payloads 0xAAAA, 0x1234, 0xBEEF -> read=0xBEEF, rx_count=3. rx_count preset path 0xFFFF + 1 flit -> 0.
